// File: rtl/keyboard_event_reader_if.sv
// Bus bundle for keyboard_event_reader: Wishbone read initiator plus byte-wide MIDI stream.
interface keyboard_event_reader_if;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_ready;

    modport master (
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o,
        input  wbm_dat_i, wbm_ack_i,
        output m_valid, m_data,
        input  m_ready
    );

    modport slave (
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o,
        output wbm_dat_i, wbm_ack_i,
        input  m_valid, m_data,
        output m_ready
    );
endinterface

// File: rtl/keyboard_event_reader.sv
// Drains the keyboard scanner event FIFO over Wishbone and re-emits each key event
// as a 3-byte MIDI Note On/Off message on a valid/ready byte stream.
module keyboard_event_reader #(
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
    parameter logic [3:0]  MIDI_CHANNEL = 4'd0,
    parameter int unsigned NOTE_OFFSET  = 36,
    parameter int unsigned NUM_KEYS     = 42,
    parameter int unsigned POLL_DIV     = 1024,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    input  logic                           irq_i,
    keyboard_event_reader_if.master        bus,
    output logic                           busy,
    output logic                           err_timeout,
    output logic [15:0]                    evt_count,
    output logic [7:0]                     drop_count
);

    localparam int unsigned POLL_W = 16;
    localparam int unsigned WAIT_W = 8;
    localparam logic [POLL_W-1:0] POLL_LAST   = POLL_W'(POLL_DIV - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST   = WAIT_W'(TIMEOUT - 1);
    localparam logic [31:0]       STATUS_ADDR = BASE_ADDR + 32'h0000_0004;
    localparam logic [31:0]       EVENT_ADDR  = BASE_ADDR + 32'h0000_0008;

    typedef enum logic [2:0] {
        IDLE, RD_STATUS, RD_EVENT, DECODE, EMIT0, EMIT1, EMIT2
    } state_t;

    state_t              state_q, state_d;
    logic [POLL_W-1:0]   poll_q, poll_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                cyc_q, cyc_d;
    logic [31:0]         adr_q, adr_d;
    logic [7:0]          key_q, key_d;
    logic [6:0]          vel_q, vel_d;
    logic                pressed_q, pressed_d;
    logic                zero_q, zero_d;
    logic [7:0]          byte1_q, byte1_d;
    logic [7:0]          byte2_q, byte2_d;
    logic                m_valid_q, m_valid_d;
    logic [7:0]          m_data_q, m_data_d;
    logic                busy_q;
    logic                err_q, err_d;
    logic [15:0]         evt_q, evt_d;
    logic [7:0]          drop_q, drop_d;

    logic                key_bad;
    logic [6:0]          note;
    logic [6:0]          vel_on;

    // Event decode from the captured fields
    assign key_bad = zero_q || (32'(key_q) >= NUM_KEYS);
    assign note    = 7'(key_q + 8'(NOTE_OFFSET));
    assign vel_on  = (vel_q == 7'd0) ? 7'd1 : vel_q;

    always_comb begin
        state_d   = state_q;
        poll_d    = poll_q;
        wait_d    = wait_q;
        cyc_d     = cyc_q;
        adr_d     = adr_q;
        key_d     = key_q;
        vel_d     = vel_q;
        pressed_d = pressed_q;
        zero_d    = zero_q;
        byte1_d   = byte1_q;
        byte2_d   = byte2_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        err_d     = err_q;
        evt_d     = evt_q;
        drop_d    = drop_q;

        case (state_q)
            IDLE: begin
                if (!enable) begin
                    poll_d = '0;
                end else if (irq_i || (poll_q == POLL_LAST)) begin
                    poll_d  = '0;
                    state_d = RD_STATUS;
                end else begin
                    poll_d = poll_q + POLL_W'(1);
                end
            end

            // Both reads share one handshake; cyc low on entry means the request is not yet issued
            RD_STATUS, RD_EVENT: begin
                if (!cyc_q) begin
                    cyc_d  = 1'b1;
                    wait_d = '0;
                    adr_d  = (state_q == RD_STATUS) ? STATUS_ADDR : EVENT_ADDR;
                end else if (bus.wbm_ack_i) begin
                    cyc_d = 1'b0;
                    if (state_q == RD_STATUS) begin
                        state_d = (bus.wbm_dat_i[1] && enable) ? RD_EVENT : IDLE;
                    end else begin
                        key_d     = bus.wbm_dat_i[7:0];
                        vel_d     = bus.wbm_dat_i[14:8];
                        pressed_d = bus.wbm_dat_i[16];
                        zero_d    = (bus.wbm_dat_i == 32'd0);
                        state_d   = DECODE;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    cyc_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end

            DECODE: begin
                if (key_bad) begin
                    if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
                    state_d = enable ? RD_STATUS : IDLE;
                end else begin
                    m_valid_d = 1'b1;
                    m_data_d  = {(pressed_q ? 4'h9 : 4'h8), MIDI_CHANNEL};
                    byte1_d   = {1'b0, note};
                    byte2_d   = pressed_q ? {1'b0, vel_on} : 8'h40;
                    state_d   = EMIT0;
                end
            end

            EMIT0: begin
                if (m_valid_q && bus.m_ready) begin
                    m_data_d = byte1_q;
                    state_d  = EMIT1;
                end
            end

            EMIT1: begin
                if (m_valid_q && bus.m_ready) begin
                    m_data_d = byte2_q;
                    state_d  = EMIT2;
                end
            end

            EMIT2: begin
                if (m_valid_q && bus.m_ready) begin
                    m_valid_d = 1'b0;
                    evt_d     = evt_q + 16'd1;
                    state_d   = enable ? RD_STATUS : IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            poll_q    <= '0;
            wait_q    <= '0;
            cyc_q     <= 1'b0;
            adr_q     <= '0;
            key_q     <= '0;
            vel_q     <= '0;
            pressed_q <= 1'b0;
            zero_q    <= 1'b0;
            byte1_q   <= '0;
            byte2_q   <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            evt_q     <= '0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            poll_q    <= poll_d;
            wait_q    <= wait_d;
            cyc_q     <= cyc_d;
            adr_q     <= adr_d;
            key_q     <= key_d;
            vel_q     <= vel_d;
            pressed_q <= pressed_d;
            zero_q    <= zero_d;
            byte1_q   <= byte1_d;
            byte2_q   <= byte2_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            busy_q    <= (state_d != IDLE);
            err_q     <= err_d;
            evt_q     <= evt_d;
            drop_q    <= drop_d;
        end
    end

    assign bus.wbm_cyc_o = cyc_q;
    assign bus.wbm_stb_o = cyc_q;
    assign bus.wbm_we_o  = 1'b0;
    assign bus.wbm_adr_o = adr_q;
    assign bus.wbm_dat_o = 32'd0;
    assign bus.m_valid   = m_valid_q;
    assign bus.m_data    = m_data_q;
    assign busy          = busy_q;
    assign err_timeout   = err_q;
    assign evt_count     = evt_q;
    assign drop_count    = drop_q;

endmodule
